// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue.
//   FETCH_XLEN      default datapath / PC / instruction width
//   FETCH_RESET_PC  default fetch PC loaded on reset
//   fetch_entry_t   one queued instruction: {pc, insn}
package fetch_pkg;

  localparam int          FETCH_XLEN     = 32;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the fetch queue's instruction-memory, redirect and consumer
// signals.
//   master : the fetch queue (issues imem requests, presents instructions)
//   slave  : the surrounding core (memory, branch unit, decode stage)
// Signals:
//   o_imem_req / o_imem_addr   request and byte address to instruction memory
//   i_imem_rdata               instruction word, one cycle after the request
//   i_redirect / i_redirect_pc flush and restart fetch at a new PC
//   o_insn_vld / i_insn_rdy    head handshake towards the consumer
//   o_insn / o_pc / o_pc_plus4 head instruction, its PC and PC+4
//   o_count                    queue occupancy
interface fetch_queue_if import fetch_pkg::*; #(
  parameter int XLEN    = FETCH_XLEN,
  parameter int IMEM_AW = 13
);

  logic               o_imem_req;
  logic [IMEM_AW-1:0] o_imem_addr;
  logic [XLEN-1:0]    i_imem_rdata;
  logic               i_redirect;
  logic [XLEN-1:0]    i_redirect_pc;
  logic               o_insn_vld;
  logic               i_insn_rdy;
  logic [XLEN-1:0]    o_insn;
  logic [XLEN-1:0]    o_pc;
  logic [XLEN-1:0]    o_pc_plus4;
  logic [4:0]         o_count;

  modport master (
    output o_imem_req, o_imem_addr,
    input  i_imem_rdata,
    input  i_redirect, i_redirect_pc,
    output o_insn_vld,
    input  i_insn_rdy,
    output o_insn, o_pc, o_pc_plus4, o_count
  );

  modport slave (
    input  o_imem_req, o_imem_addr,
    output i_imem_rdata,
    output i_redirect, i_redirect_pc,
    input  o_insn_vld,
    output i_insn_rdy,
    input  o_insn, o_pc, o_pc_plus4, o_count
  );

endinterface

// File: rtl/adder_32bit.sv
// Plain 32-bit adder used for the fetch PC increment.
//   a, b : operands
//   sum  : a + b modulo 2^32
module adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/fetch_queue_fifo.sv
// Synchronous FIFO holding fetched {pc, insn} entries.
//   clk, rst_n : clock and synchronous active-low reset
//   flush      : empty the FIFO this cycle (overrides push/pop)
//   push/wdata : write one entry at the tail
//   pop        : drop the head entry
//   rdata      : head entry, visible combinationally
//   count      : occupancy (0..DEPTH, DEPTH <= 16)
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [4:0]       count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: storage is cleared on reset so the head outputs read zero
      // afterwards; flush only rewinds the pointers and leaves data alone.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch unit: issues sequential instruction-memory requests,
// captures the one-cycle-later response and queues it with its PC for the
// decode stage. A redirect flushes everything and restarts at a new PC.
//   i_clk    : clock
//   i_reset  : synchronous active-low reset
//   bus      : fetch_queue_if.master (imem request/response, redirect,
//              head handshake, occupancy)
module fetch_queue import fetch_pkg::*; #(
  parameter int              XLEN     = FETCH_XLEN,
  parameter int              DEPTH    = 4,
  parameter int              IMEM_AW  = 13,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC)
) (
  input logic           i_clk,
  input logic           i_reset,
  fetch_queue_if.master bus
);

  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   pc_inc;
  logic [XLEN-1:0]   inflight_pc;
  logic              inflight;
  logic              pop;
  logic              push;
  logic              issue;
  logic [4:0]        count;
  logic [5:0]        occupancy;
  logic [2*XLEN-1:0] head;

  // A redirect cycle neither pops nor accepts the in-flight response.
  assign pop  = bus.o_insn_vld & bus.i_insn_rdy & ~bus.i_redirect;
  assign push = inflight & ~bus.i_redirect;

  // Slots committed after this cycle: queued + in flight - leaving now.
  // NOTE: every signal assigned in always_comb gets a value on every path,
  // so no latch is inferred.
  always_comb begin
    occupancy = 6'(count) + 6'(inflight) - 6'(pop);
    issue     = i_reset & ~bus.i_redirect & (occupancy < 6'(DEPTH));
  end

  if (XLEN == 32) begin : g_pc_add32
    adder_32bit u_pc_add (
      .a   (fetch_pc),
      .b   (32'd4),
      .sum (pc_inc)
    );
  end else begin : g_pc_add
    assign pc_inc = fetch_pc + XLEN'(4);
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!i_reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (bus.i_redirect) begin
      fetch_pc <= {bus.i_redirect_pc[XLEN-1:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= pc_inc;
        inflight_pc <= fetch_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_reset),
    .flush (bus.i_redirect),
    .push  (push),
    .wdata ({inflight_pc, bus.i_imem_rdata}),
    .pop   (pop),
    .rdata (head),
    .count (count)
  );

  assign bus.o_imem_req  = issue;
  assign bus.o_imem_addr = fetch_pc[IMEM_AW-1:0];
  assign bus.o_insn_vld  = i_reset & (count != 5'd0);
  assign bus.o_count     = i_reset ? count : 5'd0;
  assign bus.o_pc        = head[2*XLEN-1:XLEN];
  assign bus.o_insn      = head[XLEN-1:0];
  assign bus.o_pc_plus4  = head[2*XLEN-1:XLEN] + XLEN'(4);

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue. A transaction-level reference model
// (queue of {pc, insn}, one in-flight slot, fetch PC) is stepped once per
// cycle and compared against the DUT on the falling edge; directed steps add
// fixed-value checks for the reset, saturation, redirect and wrap cases.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int XLEN    = 32;
  localparam int DEPTH   = 4;
  localparam int IMEM_AW = 13;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  fetch_entry_t       mq[$];
  bit                 m_inflight = 1'b0;
  bit                 m_fresh    = 1'b0;
  logic [31:0]        m_fpc      = '0;
  logic [31:0]        m_ipc      = '0;
  logic               last_req;
  logic [IMEM_AW-1:0] last_addr;
  bit                 reached;

  fetch_queue_if #(.XLEN(XLEN), .IMEM_AW(IMEM_AW)) bus ();

  fetch_queue #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .IMEM_AW  (IMEM_AW),
    .RESET_PC (32'h0)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial forever #5 clk = ~clk;

  // Memory content: each word is tagged with its own byte address.
  function automatic logic [31:0] insn_of(input logic [IMEM_AW-1:0] a);
    return 32'hC0DE_0000 | {19'd0, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare the current cycle against the model, then advance the model.
  task automatic model_step();
    bit           m_vld, m_pop, m_req;
    int           occ;
    fetch_entry_t e;
    m_vld = rst_n && (mq.size() != 0);
    m_pop = m_vld && bus.i_insn_rdy && !bus.i_redirect;
    occ   = mq.size() + int'(m_inflight) - int'(m_pop);
    m_req = rst_n && !bus.i_redirect && (occ < DEPTH);
    check("imem_req", 32'(bus.o_imem_req), 32'(m_req));
    check("insn_vld", 32'(bus.o_insn_vld), 32'(m_vld));
    check("count", 32'(bus.o_count), rst_n ? 32'(mq.size()) : 32'd0);
    if (m_req) check("imem_addr", 32'(bus.o_imem_addr), 32'(m_fpc[IMEM_AW-1:0]));
    if (m_vld) begin
      check("head_pc", bus.o_pc, mq[0].pc);
      check("head_insn", bus.o_insn, mq[0].insn);
      check("head_pc_plus4", bus.o_pc_plus4, mq[0].pc + 32'd4);
    end else if (rst_n && m_fresh) begin
      check("reset_pc_out", bus.o_pc, 32'd0);
      check("reset_insn_out", bus.o_insn, 32'd0);
    end

    if (!rst_n) begin
      mq.delete();
      m_inflight = 1'b0;
      m_fpc      = 32'h0;
      m_fresh    = 1'b1;
    end else if (bus.i_redirect) begin
      mq.delete();
      m_inflight = 1'b0;
      m_fpc      = bus.i_redirect_pc & ~32'h3;
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_inflight) begin
        e.pc   = m_ipc;
        e.insn = insn_of(m_ipc[IMEM_AW-1:0]);
        mq.push_back(e);
        m_fresh = 1'b0;
      end
      m_inflight = m_req;
      if (m_req) begin
        m_ipc = m_fpc;
        m_fpc = m_fpc + 32'd4;
      end
    end
  endtask

  // One clock cycle: check at the falling edge, then play memory for the
  // next cycle. Returns 1 time unit after the rising edge.
  task automatic step();
    @(negedge clk);
    model_step();
    last_req  = bus.o_imem_req;
    last_addr = bus.o_imem_addr;
    @(posedge clk);
    #1;
    bus.i_imem_rdata = last_req ? insn_of(last_addr) : $urandom();
  endtask

  initial begin
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = '0;
    bus.i_insn_rdy    = 1'b1;
    bus.i_imem_rdata  = '0;

    // Reset, then a free-running stream with the consumer always ready.
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    #1;
    check("first_req", 32'(bus.o_imem_req), 32'd1);
    check("first_addr", 32'(bus.o_imem_addr), 32'h0);
    step();
    step();
    #1;
    check("vld_cycle2", 32'(bus.o_insn_vld), 32'd1);
    check("pc_cycle2", bus.o_pc, 32'h0);
    for (int k = 1; k < 10; k++) begin
      step();
      #1;
      check("pc_stream", bus.o_pc, 32'(4 * k));
      check("pc_plus4_stream", bus.o_pc_plus4, 32'(4 * k + 4));
    end

    // Consumer stalls: the queue fills and fetch stops.
    bus.i_insn_rdy = 1'b0;
    repeat (10) step();
    #1;
    check("sat_count", 32'(bus.o_count), 32'd4);
    check("sat_no_req", 32'(bus.o_imem_req), 32'd0);
    bus.i_insn_rdy = 1'b1;
    repeat (8) step();

    // Redirect while three entries are queued and one is in flight.
    bus.i_insn_rdy = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 12 && !reached; i++) begin
      if (mq.size() == 3 && m_inflight) reached = 1'b1;
      else step();
    end
    check("reach_cnt3_inflight", 32'(reached), 32'd1);
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h0000_0103;
    step();
    bus.i_redirect = 1'b0;
    #1;
    check("redir_count", 32'(bus.o_count), 32'd0);
    check("redir_vld", 32'(bus.o_insn_vld), 32'd0);
    check("redir_req", 32'(bus.o_imem_req), 32'd1);
    check("redir_addr", 32'(bus.o_imem_addr), 32'h100);
    step();
    step();
    #1;
    check("redir_first_vld", 32'(bus.o_insn_vld), 32'd1);
    check("redir_first_pc", bus.o_pc, 32'h100);

    // Redirect while the consumer is taking the head.
    bus.i_insn_rdy = 1'b1;
    repeat (4) step();
    #1;
    check("pre_flush_vld", 32'(bus.o_insn_vld), 32'd1);
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h0000_0200;
    step();
    bus.i_redirect = 1'b0;
    #1;
    check("flush_vld", 32'(bus.o_insn_vld), 32'd0);
    check("flush_count", 32'(bus.o_count), 32'd0);
    step();
    step();
    #1;
    check("flush_new_head", bus.o_pc, 32'h200);

    // PC wrap at the top of the address space.
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'hFFFF_FFF8;
    step();
    bus.i_redirect = 1'b0;
    step();
    step();
    #1;
    check("wrap_pc_f8", bus.o_pc, 32'hFFFF_FFF8);
    step();
    #1;
    check("wrap_pc_fc", bus.o_pc, 32'hFFFF_FFFC);
    check("wrap_plus4", bus.o_pc_plus4, 32'h0);
    step();
    #1;
    check("wrap_pc_0", bus.o_pc, 32'h0);
    check("wrap_insn_0", bus.o_insn, insn_of(13'h0));

    // Random traffic: stalls, redirects and occasional resets.
    for (int i = 0; i < 400; i++) begin
      bus.i_insn_rdy    = ((i % 64) < 16) ? 1'b0 : ($urandom_range(0, 3) != 0);
      bus.i_redirect    = ($urandom_range(0, 15) == 0);
      bus.i_redirect_pc = $urandom();
      rst_n             = ($urandom_range(0, 79) != 0);
      step();
    end

    // Reset pulse mid-stream with two entries queued.
    rst_n             = 1'b1;
    bus.i_insn_rdy    = 1'b0;
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h0000_0040;
    step();
    bus.i_redirect = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 12 && !reached; i++) begin
      if (mq.size() == 2) reached = 1'b1;
      else step();
    end
    check("reach_cnt2", 32'(reached), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("rst_count", 32'(bus.o_count), 32'd0);
    check("rst_vld", 32'(bus.o_insn_vld), 32'd0);
    check("rst_pc_out", bus.o_pc, 32'h0);
    check("rst_insn_out", bus.o_insn, 32'h0);
    check("rst_req", 32'(bus.o_imem_req), 32'd1);
    check("rst_addr", 32'(bus.o_imem_addr), 32'h0);
    bus.i_insn_rdy = 1'b1;
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
